// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ack bus between the MEM-stage controller and a
// variable-latency data memory.
interface mem_stage_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  // Controller side: issues requests, receives completion.
  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  // Memory side.
  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns EX/MEM load/store fields into a request/ack
// access on the data memory, stalls upstream while an access is outstanding,
// aborts on timeout, and holds the MEM/WB pipeline register.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255  // 1..255 cycles in BUSY before abort
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic [4:0]        ex_dest_reg,
  mem_stage_ctrl_if.master  dmem,
  output logic              mem_stall,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [31:0]       wb_read_data,
  output logic [31:0]       wb_alu_result,
  output logic [4:0]        wb_dest_reg,
  output logic              misalign_err,
  output logic              timeout_err
);

  localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [7:0]  count_q;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;

  logic access, aligned, start, misalign, done, abort;

  assign access   = ex_mem_read | ex_mem_write;
  assign aligned  = (ex_alu_result[1:0] == 2'b00);
  assign start    = (state_q == StIdle) & access & aligned;
  assign misalign = (state_q == StIdle) & access & ~aligned;
  assign done     = (state_q == StBusy) & dmem.ack;
  assign abort    = (state_q == StBusy) & ~dmem.ack & (count_q == LastCount);

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StBusy;
      StBusy:  if (done || abort) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Stall output; forced low during reset so every output reads 0 in reset.
  always_comb begin
    mem_stall = 1'b0;
    if (!rst) begin
      mem_stall = start |
                  ((state_q == StBusy) & ~dmem.ack & (count_q < LastCount));
    end
  end

  // Memory request registers, timeout counter and the MEM/WB register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q       <= '0;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_dest_reg   <= '0;
      misalign_err  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      misalign_err <= misalign;
      if (state_q == StIdle) begin
        if (start) begin
          req_q         <= 1'b1;
          we_q          <= ex_mem_write;  // write wins if both are set
          addr_q        <= {ex_alu_result[31:2], 2'b00};
          wdata_q       <= ex_store_data;
          count_q       <= '0;
          wb_reg_write  <= 1'b0;
          wb_mem_to_reg <= 1'b0;
          wb_read_data  <= '0;
          wb_alu_result <= '0;
          wb_dest_reg   <= '0;
        end else begin
          // Plain ALU op or dropped misaligned access.
          wb_reg_write  <= ex_reg_write & ~misalign;
          wb_mem_to_reg <= ex_mem_to_reg;
          wb_read_data  <= '0;
          wb_alu_result <= ex_alu_result;
          wb_dest_reg   <= ex_dest_reg;
        end
      end else begin
        count_q <= count_q + 8'd1;
        if (done || abort) begin
          req_q         <= 1'b0;
          wb_reg_write  <= ex_reg_write & done;
          wb_mem_to_reg <= ex_mem_to_reg;
          wb_read_data  <= (done && !we_q) ? dmem.rdata : 32'd0;
          wb_alu_result <= ex_alu_result;
          wb_dest_reg   <= ex_dest_reg;
          if (abort) timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage reader of the EX/MEM pipeline register outputs in the pipelined MIPS core.
- Turns load/store control and data fields into a request/ack handshake on a variable-latency data memory.
- Stalls the upstream pipeline while an access is outstanding.
- Holds the MEM/WB pipeline register that feeds write-back.

Parameters:
- TIMEOUT, 255: max cycles in BUSY waiting for dmem_ack before the access is aborted (range 1..255).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- ex_reg_write  in  1  RegWrite from EX/MEM register
- ex_mem_to_reg  in  1  MemToReg from EX/MEM register
- ex_mem_read  in  1  MemRead from EX/MEM register
- ex_mem_write  in  1  MemWrite from EX/MEM register
- ex_alu_result  in  32  effective address / ALU result
- ex_store_data  in  32  ReadData2 (store data)
- ex_dest_reg  in  5  destination register number
- dmem_req  out  1  memory request, held until ack or abort
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  32  word address (bits[1:0] always 0)
- dmem_wdata  out  32  store data
- dmem_ack  in  1  memory completion, one-cycle pulse
- dmem_rdata  in  32  read data, valid with dmem_ack
- mem_stall  out  1  upstream must hold EX/MEM contents when 1
- wb_reg_write  out  1  MEM/WB RegWrite
- wb_mem_to_reg  out  1  MEM/WB MemToReg
- wb_read_data  out  32  MEM/WB load data
- wb_alu_result  out  32  MEM/WB ALU result
- wb_dest_reg  out  5  MEM/WB destination register
- misalign_err  out  1  one-cycle pulse: access dropped because of a misaligned address
- timeout_err  out  1  sticky: an access was aborted by timeout

Behaviour:
- Reset (async, any state, including mid-transaction):
  - state=IDLE, timeout counter=0.
  - All outputs 0, including dmem_req and timeout_err.
  - Any pending ack is discarded.
- Definitions:
  - access = ex_mem_read | ex_mem_write
  - aligned = (ex_alu_result[1:0] == 2'b00)
- mem_stall (combinational) = (IDLE & access & aligned) | (BUSY & ~dmem_ack & count < TIMEOUT-1).
- Bubble: wb_reg_write=0, wb_mem_to_reg=0, wb_dest_reg=0, wb_read_data=0, wb_alu_result=0.
- IDLE, no access:
  - MEM/WB loads the ex_* fields at the next edge; wb_read_data=0.
  - Latency 1 cycle, no stall.
- IDLE, access, misaligned:
  - No request, no stall.
  - MEM/WB loads the ex_* fields with wb_reg_write forced to 0 and wb_read_data=0.
  - misalign_err=1 for the following cycle.
- IDLE, access, aligned:
  - At the next edge: dmem_req=1, dmem_addr=ex_alu_result, dmem_wdata=ex_store_data, dmem_we=ex_mem_write, count=0, state -> BUSY.
  - MEM/WB loads a bubble.
  - If ex_mem_read and ex_mem_write are both 1, the write wins: dmem_we=1, wb_read_data=0.
- BUSY:
  - dmem_addr, dmem_wdata and dmem_we are frozen; count increments each cycle.
  - dmem_ack=1: MEM/WB loads the ex_* fields (held stable by the stall), wb_read_data = dmem_rdata if it was a read, else 0. dmem_req drops at the same edge; state -> IDLE.
  - Stall is low in the ack cycle, so EX/MEM advances at that same edge.
  - Minimum memory-op cost: 2 cycles (IDLE detect + BUSY with immediate ack).
  - No ack and count == TIMEOUT-1: abort. dmem_req=0, timeout_err=1 (sticky until rst), MEM/WB loads ex_* with wb_reg_write=0, state -> IDLE.
  - Stall deasserts in the abort cycle.
- dmem_ack outside BUSY is ignored.
- dmem_rdata is sampled only when BUSY & dmem_ack.
- Back-to-back memory ops: the second op is detected in IDLE the cycle after the first completes. No request is lost and none is issued twice.

Test Plan:
- Reset: assert rst mid-BUSY with dmem_req=1 -> all outputs 0 immediately (async), state IDLE; a later ack pulse has no effect.
- ALU op pass-through: ex_reg_write=1, ex_alu_result=0x0000_1234, dest=5, no access -> next cycle wb_alu_result=0x1234, wb_dest_reg=5, wb_reg_write=1, mem_stall never 1.
- Load with 3-cycle memory latency: ex_mem_read=1, addr=0x100, ack on the 3rd BUSY cycle with rdata=0xDEAD_BEEF -> dmem_req high for exactly 3 cycles, addr=0x100, we=0; mem_stall high 3 cycles; then wb_read_data=0xDEADBEEF, wb_mem_to_reg=1.
- Store, immediate ack: ex_mem_write=1, addr=0x40, data=0xA5A5_A5A5 -> one-cycle req with we=1, wdata=0xA5A5A5A5, total 2 cycles; wb_read_data=0.
- Misaligned load addr=0x102 -> no dmem_req, no stall, misalign_err pulses once, wb_reg_write=0.
- Timeout with TIMEOUT=4 and no ack -> req high exactly 4 cycles, then timeout_err=1 sticky and wb_reg_write=0; a following load at 0x200 acked immediately completes normally.
